// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: requester-side and APB-side signals of the round-robin APB master
interface apb_rr_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          busy;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic                          PWRITE;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic                          PSELx;
  logic                          PENABLE;
  logic                          PREADY;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PSLVERR;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    output req_gnt, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA, PSLVERR,
    input  req_gnt, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );
endinterface

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one slave port among NUM_REQ requesters, with wait-state timeout
module apb_rr_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 16
) (
  input logic PCLK,
  input logic PRESETn,
  apb_rr_master_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [IW-1:0] last, cur, win;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic g_write, take;
  // Lowest valid index wins, then overridden by the lowest valid index above last.
  always_comb begin
    win = '0;
    g_addr = '0;
    g_wdata = '0;
    g_write = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i]) begin
        win = IW'(i);
        g_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_write = bus.req_write[i];
      end
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && i > int'(last)) begin
        win = IW'(i);
        g_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_write = bus.req_write[i];
      end
    take = |bus.req_valid && (state == IDLE || (state == ACCESS && bus.PREADY));
  end
  assign bus.req_gnt = take ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      last <= IW'(NUM_REQ - 1);
      cur <= '0;
      cnt <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.busy <= 1'b0;
      bus.PADDR <= '0;
      bus.PWRITE <= 1'b0;
      bus.PWDATA <= '0;
      bus.PSELx <= 1'b0;
      bus.PENABLE <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      case (state)
        SETUP: begin
          state <= ACCESS;
          bus.PENABLE <= 1'b1;
          cnt <= '0;
        end
        ACCESS:
          if (bus.PREADY || (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1))) begin
            bus.rsp_valid <= NUM_REQ'(1) << cur;
            bus.rsp_rdata <= bus.PREADY && !bus.PWRITE ? bus.PRDATA : '0;
            bus.rsp_err <= !bus.PREADY || bus.PSLVERR;
            state <= IDLE;
            bus.PSELx <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.busy <= 1'b0;
          end else cnt <= &cnt ? cnt : cnt + CW'(1);
        default: ;
      endcase
      if (take) begin
        state <= SETUP;
        last <= win;
        cur <= win;
        bus.PADDR <= g_addr;
        bus.PWRITE <= g_write;
        bus.PWDATA <= g_write ? g_wdata : bus.PWDATA;
        bus.PSELx <= 1'b1;
        bus.PENABLE <= 1'b0;
        bus.busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: directed checks of grant order, APB phasing, wait states, timeout and reset
module tb_apb_rr_master;
  logic PCLK = 1'b0;
  logic PRESETn;
  int total = 0;
  int bad = 0;
  apb_rr_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(2)) bus ();
  apb_rr_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(2), .TIMEOUT(4)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge PCLK);
    #1;
  endtask
  initial begin
    PRESETn = 1'b0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    bus.PSLVERR = 1'b0;
    tick;
    tick;
    chk("rst_psel", bus.PSELx, 0);
    chk("rst_pen", bus.PENABLE, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_paddr", bus.PADDR, 0);
    PRESETn = 1'b1;
    tick;
    // zero-wait write from requester 0
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr = {32'h0, 32'h10};
    bus.req_wdata = {32'h0, 32'hA5A5_0001};
    bus.PREADY = 1'b1;
    #1 chk("w_gnt", bus.req_gnt, 2'b01);
    tick;
    bus.req_valid = '0;
    chk("w_setup_psel", bus.PSELx, 1);
    chk("w_setup_pen", bus.PENABLE, 0);
    chk("w_paddr", bus.PADDR, 32'h10);
    chk("w_pwrite", bus.PWRITE, 1);
    chk("w_pwdata", bus.PWDATA, 32'hA5A5_0001);
    chk("w_busy", bus.busy, 1);
    tick;
    chk("w_acc_psel", bus.PSELx, 1);
    chk("w_acc_pen", bus.PENABLE, 1);
    tick;
    chk("w_rspv", bus.rsp_valid, 2'b01);
    chk("w_err", bus.rsp_err, 0);
    chk("w_rdata", bus.rsp_rdata, 0);
    chk("w_idle_psel", bus.PSELx, 0);
    chk("w_idle_pen", bus.PENABLE, 0);
    chk("w_idle_busy", bus.busy, 0);
    // read from requester 1 with three wait states and a slave error
    bus.req_valid = 2'b10;
    bus.req_write = 2'b00;
    bus.req_addr = {32'h24, 32'h10};
    bus.PREADY = 1'b0;
    #1 chk("r_gnt", bus.req_gnt, 2'b10);
    tick;
    bus.req_valid = '0;
    chk("r_paddr", bus.PADDR, 32'h24);
    chk("r_pwrite", bus.PWRITE, 0);
    chk("r_pwdata_held", bus.PWDATA, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("r_wait_pen", bus.PENABLE, 1);
      chk("r_wait_paddr", bus.PADDR, 32'h24);
      chk("r_wait_rspv", bus.rsp_valid, 0);
    end
    tick;
    chk("r_last_paddr", bus.PADDR, 32'h24);
    chk("r_last_pen", bus.PENABLE, 1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hDEAD_BEEF;
    bus.PSLVERR = 1'b1;
    tick;
    chk("r_rspv", bus.rsp_valid, 2'b10);
    chk("r_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("r_err", bus.rsp_err, 1);
    chk("r_psel", bus.PSELx, 0);
    bus.PSLVERR = 1'b0;
    bus.PRDATA = '0;
    // both requesters hold requests for four back-to-back transfers
    bus.req_valid = 2'b11;
    bus.req_write = 2'b11;
    bus.req_addr = {32'h200, 32'h100};
    bus.req_wdata = {32'hB2, 32'hB1};
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick;
      chk("rr_gnt", bus.req_gnt, (i % 2 == 1 || i == 8) ? 2'b00 : (i % 4 == 0 ? 2'b01 : 2'b10));
      if (i > 0) chk("rr_psel", bus.PSELx, 1);
      if (i % 2 == 1) chk("rr_paddr", bus.PADDR, i % 4 == 1 ? 32'h100 : 32'h200);
      if (i == 3 || i == 5 || i == 7) chk("rr_rspv", bus.rsp_valid, i == 5 ? 2'b10 : 2'b01);
      if (i == 7) bus.req_valid = '0;
    end
    tick;
    chk("rr_end_psel", bus.PSELx, 0);
    chk("rr_end_rspv", bus.rsp_valid, 2'b10);
    // timeout on requester 0 with requester 1 pending
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr = {32'h400, 32'h300};
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h1234;
    #1 chk("to_gnt", bus.req_gnt, 2'b01);
    tick;
    bus.req_valid = 2'b10;
    #1 chk("to_setup_gnt", bus.req_gnt, 0);
    for (int i = 2; i < 6; i++) begin
      tick;
      chk("to_acc_gnt", bus.req_gnt, 0);
      chk("to_acc_pen", bus.PENABLE, 1);
      chk("to_acc_rspv", bus.rsp_valid, 0);
    end
    tick;
    chk("to_psel", bus.PSELx, 0);
    chk("to_pen", bus.PENABLE, 0);
    chk("to_rspv", bus.rsp_valid, 2'b01);
    chk("to_err", bus.rsp_err, 1);
    chk("to_rdata", bus.rsp_rdata, 0);
    chk("to_next_gnt", bus.req_gnt, 2'b10);
    tick;
    bus.req_valid = '0;
    chk("to_next_paddr", bus.PADDR, 32'h400);
    chk("to_next_psel", bus.PSELx, 1);
    tick;
    chk("mid_pen", bus.PENABLE, 1);
    // reset in the middle of an ACCESS phase
    PRESETn = 1'b0;
    #1;
    chk("arst_psel", bus.PSELx, 0);
    chk("arst_pen", bus.PENABLE, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_paddr", bus.PADDR, 0);
    chk("arst_rspv", bus.rsp_valid, 0);
    tick;
    PRESETn = 1'b1;
    bus.PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rspv", bus.rsp_valid, 0);
      chk("post_psel", bus.PSELx, 0);
    end
    bus.req_valid = 2'b11;
    #1 chk("post_gnt", bus.req_gnt, 2'b01);
    tick;
    bus.req_valid = '0;
    chk("post_paddr", bus.PADDR, 32'h300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
